// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Turns the hazard detector's load-use stall request, the EX-stage branch-taken flush and the
//   data-memory wait into per-stage write enables and bubble/flush strobes for the PC and the
//   IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers. It also tracks multi-cycle memory waits
//   and keeps saturating stall and flush performance counters.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   hdu_stall    in   load-use stall request from the hazard detector
//   br_taken_ex  in   branch/jump resolved taken in EX (DE and IF hold wrong-path instructions)
//   dm_req_mem   in   MEM stage holds a valid load/store this cycle
//   dm_ready     in   data memory completes the MEM-stage access this cycle
//   pc_we        out  PC update enable
//   ifde_we      out  IF/DE write enable
//   ifde_flush   out  IF/DE load NOP
//   deex_we      out  DE/EX write enable
//   deex_bubble  out  DE/EX load NOP
//   exmem_we     out  EX/MEM write enable
//   memwb_bubble out  MEM/WB load NOP
//   mem_wait     out  high while in the memory-wait state
//   err          out  sticky wait-timeout or stall-protocol error
//   stall_cnt    out  saturating count of cycles with pc_we low
//   flush_cnt    out  saturating count of cycles with ifde_flush high

module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WAIT_TMO  = 64,
  parameter int unsigned STALL_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdu_stall,
  input  logic             br_taken_ex,
  input  logic             dm_req_mem,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic             ifde_we,
  output logic             ifde_flush,
  output logic             deex_we,
  output logic             deex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_wait,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TmrW = $clog2(WAIT_TMO + 1);
  localparam int unsigned StlW = $clog2(STALL_MAX + 2);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  wait_tmr_q, wait_tmr_d;
  logic [StlW-1:0]  stall_run_q, stall_run_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, flush, load_use;

  // Freeze applies in either state; a ready access never freezes, so the completion cycle of a
  // wait falls through to the lower-priority rules.
  assign freeze   = dm_req_mem & ~dm_ready;
  assign flush    = ~freeze & br_taken_ex;
  assign load_use = ~freeze & ~br_taken_ex & hdu_stall;

  always_comb begin
    pc_we        = 1'b1;
    ifde_we      = 1'b1;
    ifde_flush   = 1'b0;
    deex_we      = 1'b1;
    deex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    if (freeze) begin
      pc_we        = 1'b0;
      ifde_we      = 1'b0;
      deex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (flush) begin
      ifde_flush  = 1'b1;
      deex_bubble = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifde_we     = 1'b0;
      deex_bubble = 1'b1;
    end
    // Strobes are combinational, so hold them low asynchronously while reset is asserted.
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifde_we      = 1'b0;
      ifde_flush   = 1'b0;
      deex_we      = 1'b0;
      deex_bubble  = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  always_comb begin
    state_d = freeze ? StMemWait : StRun;

    // Wait timer saturates at WAIT_TMO; the pipeline stays frozen after a timeout.
    wait_tmr_d = '0;
    if (freeze) begin
      wait_tmr_d = (wait_tmr_q == TmrW'(WAIT_TMO)) ? wait_tmr_q : wait_tmr_q + 1'b1;
    end

    // Consecutive load-use run length; freeze cycles hold it, any other cycle clears it.
    stall_run_d = '0;
    if (freeze) begin
      stall_run_d = stall_run_q;
    end else if (load_use) begin
      stall_run_d = (stall_run_q == StlW'(STALL_MAX + 1)) ? stall_run_q : stall_run_q + 1'b1;
    end

    err_d = err_q;
    if (wait_tmr_d == TmrW'(WAIT_TMO) || stall_run_d == StlW'(STALL_MAX + 1)) begin
      err_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    flush_cnt_d = flush_cnt_q;
    if (ifde_flush && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_tmr_q  <= '0;
      stall_run_q <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_tmr_q  <= wait_tmr_d;
      stall_run_q <= stall_run_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_wait  = (state_q == StMemWait);
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
